mod_reduce: RTL and testbench
=============================

// Module: mod_reduce
// PURPOSE
//  Sequential modular reducer: remainder = value mod modulus, radix-2 restoring shift-subtract.
//  Sits directly downstream of the exponentiation stage in the Diffie-Hellman datapath.
//  Takes its 64-bit raw power and produces the 32-bit public/shared key (g^x mod p).
//  One dividend bit per cycle; constant latency by default.
// PARAMETERS
//  DIVIDEND_W  64  width of value (matches exponentiation result)
//  MOD_W       32  width of modulus and remainder
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous reset, active low
//  start      in   1            request pulse; sampled only in IDLE
//  value      in   DIVIDEND_W   dividend; captured on accepted start
//  modulus    in   MOD_W        prime p; captured on accepted start
//  remainder  out  MOD_W        value mod modulus; valid from done, held until next accept
//  busy       out  1            high while in RUN or DONE
//  done       out  1            one-cycle pulse, result valid
//  err        out  1            modulus==0 on last request; qualified by done, held like remainder
// BEHAVIOUR
//  - Reset (rst low, any time incl. mid-operation): all state cleared, FSM->IDLE.
//    Output reset values: remainder=0, busy=0, done=0, err=0. No partial result is retained.
//  - FSM states and transitions:
//    IDLE -> RUN on start. RUN -> DONE after the last iteration. DONE -> IDLE unconditionally after 1 cycle.
//  - Accept (edge E0, IDLE & start):
//    shift reg <= value; mod reg <= modulus; rem reg <= 0; count <= 0; state -> RUN.
//  - Iteration (edges E1..E_DIVIDEND_W):
//    t = {rem, shift[MSB]}, computed MOD_W+1 bits wide to avoid overflow.
//    If t >= mod: rem <= t - mod, else rem <= t. Then shift <<= 1; count++.
//  - Last iteration edge (count == DIVIDEND_W-1) also moves the FSM to DONE and registers done=1.
//    done is therefore high in the cycle following edge E_DIVIDEND_W, i.e. 64 cycles after accept.
//  - rem is never >= mod after an iteration; remainder output = rem[MOD_W-1:0].
//  - modulus==0 at accept: skip RUN. At E1 go to DONE with err=1, remainder=0, done=1.
//  - start while busy: ignored, no effect on the in-flight operation.
//  - start held high across DONE->IDLE: a new request is accepted at the first IDLE edge.
//    Back-to-back requests therefore have throughput 1 per DIVIDEND_W+2 cycles.
//  - value and modulus may change freely after accept; only the captured copies are used.
//  - value < modulus is legal and yields remainder=value. value==0 yields 0.
// CONFIGURATION
//  MOD_REDUCE_EARLY_EXIT_EN
//  - Defined: at accept, if modulus!=0 and value < modulus, go straight to DONE.
//    done pulses in the cycle after E1 with remainder=value, err=0.
//  - Undefined (default): latency is always DIVIDEND_W cycles for non-zero modulus.
//    Data-independent timing; required for key material, side-channel safe.
// STRUCTURE
//  - Shared package dh_pkg holds: DH_DIVIDEND_W=64, DH_MOD_W=32, and the state encoding
//    localparams MR_IDLE=2'd0, MR_RUN=2'd1, MR_DONE=2'd2.
//  - Sub-module mod_sub_step (combinational, one conditional-subtract step).
//    Inputs {rem, bit_in, mod}; output next rem.
//    Isolated so a radix-4 variant can instantiate two in series later.
//  - Top holds the FSM, counter (clog2(DIVIDEND_W)+1 bits), and the shift/rem/mod registers.
// TESTING
//  - value=100, modulus=7, start 1 cycle -> done exactly 64 cycles later, remainder=2, err=0.
//  - value=64'hFFFF_FFFF_FFFF_FFFF, modulus=32'hFFFF_FFFB -> remainder=24 (2^32 = 5 mod p).
//  - modulus=0, value=12345 -> done 1 cycle after accept, err=1, remainder=0; next request clears err.
//  - accept 100 mod 7; pulse start with 9 mod 5 at cycle 30 -> ignored, final remainder=2.
//  - accept; drop rst at cycle 20 for 1 cycle -> busy=done=err=remainder=0, IDLE.
//    A new request 1000 mod 13 then gives 12.
//  - value=5, modulus=23 -> remainder=5; done after 1 cycle with MOD_REDUCE_EARLY_EXIT_EN, after 64 without.

Source files
------------

// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman datapath.
// Holds datapath widths and the modular-reducer state encoding.
package dh_pkg;

    localparam int DH_DIVIDEND_W = 64;
    localparam int DH_MOD_W      = 32;

    typedef logic [1:0] mr_state_t;

    localparam mr_state_t MR_IDLE = 2'd0;
    localparam mr_state_t MR_RUN  = 2'd1;
    localparam mr_state_t MR_DONE = 2'd2;

endpackage

// File: rtl/mod_sub_step.sv
// One restoring shift-subtract step: next = {rem,bit} mod m.
// Kept separate so a radix-4 reducer can chain two of these.
module mod_sub_step
    import dh_pkg::*;
#(
    parameter int MOD_W = DH_MOD_W
) (
    input  logic [MOD_W-1:0] i_rem,
    input  logic             i_bit_in,
    input  logic [MOD_W-1:0] i_mod,
    output logic [MOD_W-1:0] o_rem
);

    logic [MOD_W:0] w_t;
    logic [MOD_W:0] w_m;
    logic           w_ge;

    assign w_t  = {i_rem, i_bit_in};
    assign w_m  = {1'b0, i_mod};
    assign w_ge = (w_t >= w_m);

    // rem < mod on entry, so t - mod < mod fits in MOD_W bits
    assign o_rem = w_ge ? MOD_W'(w_t - w_m) : w_t[MOD_W-1:0];

endmodule

// File: rtl/mod_reduce.sv
// Sequential radix-2 modular reducer: remainder = value mod modulus.
// Optional early exit for value < modulus: MOD_REDUCE_EARLY_EXIT_EN.
module mod_reduce
    import dh_pkg::*;
#(
    parameter int DIVIDEND_W = DH_DIVIDEND_W,
    parameter int MOD_W      = DH_MOD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] value,
    input  logic [MOD_W-1:0]      modulus,
    output logic [MOD_W-1:0]      remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = $clog2(DIVIDEND_W) + 1;

    mr_state_t             r_state;
    mr_state_t             w_state_nxt;
    logic [DIVIDEND_W-1:0] r_shift;
    logic [MOD_W-1:0]      r_mod;
    logic [MOD_W-1:0]      r_rem;
    logic [CNT_W-1:0]      r_count;
    logic                  r_zero;
    logic                  r_early;
    logic                  r_err;
    logic [MOD_W-1:0]      w_rem_nxt;
    logic                  w_last;
    logic                  w_early_acc;

`ifdef MOD_REDUCE_EARLY_EXIT_EN
    assign w_early_acc = (modulus != '0) &&
                         (value < DIVIDEND_W'(modulus));
`else
    assign w_early_acc = 1'b0;
`endif

    assign w_last = (r_count == CNT_W'(DIVIDEND_W - 1));

    mod_sub_step #(
        .MOD_W (MOD_W)
    ) u_step (
        .i_rem    (r_rem),
        .i_bit_in (r_shift[DIVIDEND_W-1]),
        .i_mod    (r_mod),
        .o_rem    (w_rem_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; zero modulus and early exit leave RUN after one edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MR_IDLE: begin
                if (start) begin
                    w_state_nxt = MR_RUN;
                end
            end
            MR_RUN: begin
                if (r_zero || r_early || w_last) begin
                    w_state_nxt = MR_DONE;
                end
            end
            MR_DONE: w_state_nxt = MR_IDLE;
            default: w_state_nxt = MR_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (r_state != MR_IDLE);
        done = (r_state == MR_DONE);
    end

    // Datapath: capture on accept, one dividend bit per RUN cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_mod   <= '0;
            r_rem   <= '0;
            r_count <= '0;
            r_zero  <= 1'b0;
            r_early <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                MR_IDLE: begin
                    if (start) begin
                        r_shift <= value;
                        r_mod   <= modulus;
                        r_rem   <= '0;
                        r_count <= '0;
                        r_zero  <= (modulus == '0);
                        r_early <= w_early_acc;
                        r_err   <= 1'b0;
                    end
                end
                MR_RUN: begin
                    if (r_zero) begin
                        r_rem <= '0;
                        r_err <= 1'b1;
                    end else if (r_early) begin
                        r_rem <= r_shift[MOD_W-1:0];
                    end else begin
                        r_rem   <= w_rem_nxt;
                        r_shift <= r_shift << 1;
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign remainder = r_rem;
    assign err       = r_err;

endmodule

// File: tb/tb_mod_reduce.sv
// Self-checking bench for mod_reduce: directed cases plus random
// requests compared every cycle against a timing/arithmetic model.
module tb_mod_reduce;

`ifdef MOD_REDUCE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] value = '0;
    logic [31:0] modulus = '0;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_on = 1'b0;

    mod_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .value     (value),
        .modulus   (modulus),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, got, exp);
    endtask

    // Model: cycles since accept (-1 idle), expected latency and result
    int          m_t = -1;
    int          m_lat = 64;
    logic [63:0] m_v;
    logic [31:0] m_m;
    logic [31:0] m_rem = '0;
    logic        m_err = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t   = -1;
            m_rem = '0;
            m_err = 1'b0;
        end else if (m_t < 0) begin
            if (start) begin
                m_v = value;
                m_m = modulus;
                if (m_m == 0) m_lat = 1;
                else if (EARLY && m_v < {32'b0, m_m}) m_lat = 1;
                else m_lat = 64;
                m_t = 0;
            end
        end else begin
            m_t++;
            if (m_t == m_lat) begin
                m_err = (m_m == 0);
                m_rem = m_err ? 32'd0 : 32'(m_v % {32'b0, m_m});
            end else if (m_t == m_lat + 1) begin
                m_t = -1;
            end
        end
    end

    // Per-cycle compare; remainder/err only meaningful at done or idle
    always @(negedge clk) begin
        if (rst && chk_on) begin
            chk("busy", busy, m_t >= 0);
            chk("done", done, m_t == m_lat);
            if (m_t < 0 || m_t == m_lat) begin
                chk("rem", remainder, m_rem);
                chk("err", err, m_err);
            end
        end
    end

    // Issue a one-cycle request from an idle negedge
    task automatic req(input logic [63:0] v, input logic [31:0] m);
        start   = 1'b1;
        value   = v;
        modulus = m;
        @(negedge clk);
        start   = 1'b0;
        value   = {$urandom, $urandom};
        modulus = $urandom;
    endtask

    task automatic wait_done(input int n0, input logic [31:0] er,
                             input logic ee, input int elat,
                             input string nm);
        int n = n0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, n, elat);
        chk({nm, "_rem"}, remainder, er);
        chk({nm, "_err"}, err, ee);
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [63:0] v;
        logic [31:0] m;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rem", remainder, 0);
        rst    = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        req(64'd100, 32'd7);
        wait_done(0, 32'd2, 1'b0, 64, "d100m7");

        req(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB);
        wait_done(0, 32'd24, 1'b0, 64, "dmax");

        req(64'd12345, 32'd0);
        wait_done(0, 32'd0, 1'b1, 1, "dzero");
        chk("zero_hold_err", err, 1);
        req(64'd100, 32'd7);
        wait_done(0, 32'd2, 1'b0, 64, "dclr");

        req(64'd100, 32'd7);
        repeat (29) @(negedge clk);
        start   = 1'b1;
        value   = 64'd9;
        modulus = 32'd5;
        @(negedge clk);
        start   = 1'b0;
        wait_done(30, 32'd2, 1'b0, 64, "dign");

        req(64'd777777, 32'd991);
        repeat (19) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_rem", remainder, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        req(64'd1000, 32'd13);
        wait_done(0, 32'd12, 1'b0, 64, "d1000m13");

        req(64'd5, 32'd23);
        wait_done(0, 32'd5, 1'b0, EARLY ? 1 : 64, "d5m23");

        req(64'd0, 32'd9);
        wait_done(0, 32'd0, 1'b0, EARLY ? 1 : 64, "dv0");

        start   = 1'b1;
        value   = 64'd100;
        modulus = 32'd7;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        @(negedge clk);
        n++;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("b2b_gap", n, 66);
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: begin m = 32'd0; v = {$urandom, $urandom}; end
                1: begin m = $urandom_range(1, 20); v = {$urandom, $urandom}; end
                2: begin
                    m = $urandom | 32'd1;
                    v = {32'b0, $urandom} % {32'b0, m};
                end
                default: begin m = $urandom; v = {$urandom, $urandom}; end
            endcase
            req(v, m);
            n = 0;
            while (!done && n < 200) begin
                start = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            if (n >= 200) chk("rand_timeout", n, 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
